// File: rtl/chip_burst_engine.sv
// chip_burst_engine
//   Behavioural DRAM chip model with a command interface. Tracks an open row
//   per bank, turns one RD/WR command into a BL-beat burst (sequential wrap
//   inside the BL-aligned column block), applies CWL before write data and CL
//   before read data, and raises a sticky err on illegal command sequences.
//
// Ports
//   clk, rst_n         : rising-edge clock, synchronous active-low reset
//   cmd_valid/ready    : command handshake; ready only while idle
//   cmd                : 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA (6-7 illegal)
//   bg, ba             : target bank group / bank
//   row                : row for ACT
//   column             : start column for RD/WR
//   dqin               : write data beat
//   dqout, dq_valid    : read data beat (0 when not valid) and its valid flag
//   err                : sticky illegal-command flag, cleared only by reset
module chip_burst_engine #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int CHWIDTH      = 5,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int CL           = 4,
    parameter int CWL          = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd,
    input  logic [BGWIDTH-1:0]      bg,
    input  logic [BAWIDTH-1:0]      ba,
    input  logic [CHWIDTH-1:0]      row,
    input  logic [COLWIDTH-1:0]     column,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic [DEVICE_WIDTH-1:0] dqout,
    output logic                    dq_valid,
    output logic                    err
);

    localparam int BKW    = BGWIDTH + BAWIDTH;
    localparam int NBANKS = 2**BKW;
    localparam int AW     = BKW + CHWIDTH + COLWIDTH;
    localparam int WCW    = (CWL > 1) ? $clog2(CWL) : 1;
    localparam logic [COLWIDTH-1:0] BMASK = COLWIDTH'(BL - 1);

    typedef enum logic [1:0] {IDLE, WR_WAIT, WR_BURST, RD_BURST} state_t;
    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5
    } cmd_t;

    state_t state, state_d;

    logic [DEVICE_WIDTH-1:0] mem [2**AW];
    logic [NBANKS-1:0]       bank_open;
    logic [CHWIDTH-1:0]      open_row [NBANKS];

    logic [BKW-1:0]      lat_bank;
    logic [CHWIDTH-1:0]  lat_row;
    logic [COLWIDTH-1:0] lat_col;
    logic [COLWIDTH-1:0] beat;
    logic [WCW-1:0]      wait_cnt;

    logic [BKW-1:0]      sel_bank;
    logic                sel_open;
    logic                rd_issue, wr_en, set_err;
    logic                do_act, do_pre, do_prea, do_latch;

    logic [BKW-1:0]      cur_bank;
    logic [CHWIDTH-1:0]  cur_row;
    logic [COLWIDTH-1:0] cur_col;
    logic [COLWIDTH-1:0] beat_col;
    logic [AW-1:0]       mem_addr;

    logic [CL:0]             rd_vld;
    logic [DEVICE_WIDTH-1:0] rd_dat [CL+1];

    assign sel_bank  = {bg, ba};
    assign sel_open  = bank_open[sel_bank];
    assign cmd_ready = (state == IDLE);

    // Beat 0 of a read is fetched on the accept edge itself, so while idle the
    // address comes straight from the command inputs; later beats use the
    // values latched at accept.
    always_comb begin
        cur_bank = lat_bank;
        cur_row  = lat_row;
        cur_col  = lat_col;
        if (state == IDLE) begin
            cur_bank = sel_bank;
            cur_row  = open_row[sel_bank];
            cur_col  = column;
        end
        beat_col = (cur_col & ~BMASK) | ((cur_col + beat) & BMASK);
        mem_addr = {cur_bank, cur_row, beat_col};
    end

    always_comb begin
        state_d  = state;
        rd_issue = 1'b0;
        wr_en    = 1'b0;
        set_err  = 1'b0;
        do_act   = 1'b0;
        do_pre   = 1'b0;
        do_prea  = 1'b0;
        do_latch = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_NOP: ;
                        CMD_ACT: begin
                            if (sel_open) set_err = 1'b1;
                            else          do_act  = 1'b1;
                        end
                        CMD_RD: begin
                            if (!sel_open) begin
                                set_err = 1'b1;
                            end else begin
                                rd_issue = 1'b1;
                                do_latch = 1'b1;
                                state_d  = RD_BURST;
                            end
                        end
                        CMD_WR: begin
                            if (!sel_open) begin
                                set_err = 1'b1;
                            end else begin
                                do_latch = 1'b1;
                                state_d  = (CWL == 1) ? WR_BURST : WR_WAIT;
                            end
                        end
                        CMD_PRE:  do_pre  = 1'b1;
                        CMD_PREA: do_prea = 1'b1;
                        default:  set_err = 1'b1;
                    endcase
                end
            end
            WR_WAIT: begin
                if (wait_cnt == WCW'(CWL - 2)) state_d = WR_BURST;
            end
            WR_BURST: begin
                wr_en = 1'b1;
                if (beat == BMASK) state_d = IDLE;
            end
            RD_BURST: begin
                rd_issue = 1'b1;
                if (beat == BMASK) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            bank_open <= '0;
            lat_bank  <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
        end else begin
            state <= state_d;
            if (set_err) err <= 1'b1;
            if (do_latch) begin
                lat_bank <= sel_bank;
                lat_row  <= open_row[sel_bank];
                lat_col  <= column;
            end
            if (state_d == IDLE)      beat <= '0;
            else if (rd_issue || wr_en) beat <= beat + 1'b1;
            if (state == WR_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                  wait_cnt <= '0;
            if (do_act)  bank_open[sel_bank] <= 1'b1;
            if (do_pre)  bank_open[sel_bank] <= 1'b0;
            if (do_prea) bank_open           <= '0;
        end
    end

    // Row registers and storage are not reset; a closed bank ignores its row.
    always_ff @(posedge clk) begin
        if (rst_n && do_act) open_row[sel_bank] <= row;
        if (rst_n && wr_en)  mem[mem_addr]      <= dqin;
    end

    // CL+1 stages: a beat fetched on edge e is presented after edge e+CL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld <= '0;
            for (int unsigned i = 0; i <= CL; i++) rd_dat[i] <= '0;
        end else begin
            rd_vld    <= {rd_vld[CL-1:0], rd_issue};
            rd_dat[0] <= rd_issue ? mem[mem_addr] : '0;
            for (int unsigned i = 1; i <= CL; i++) rd_dat[i] <= rd_dat[i-1];
        end
    end

    assign dq_valid = rd_vld[CL];
    assign dqout    = rd_dat[CL];

endmodule

// File: tb/tb_chip_burst_engine.sv
// Testbench for chip_burst_engine: directed command sequences checked every
// cycle against a cycle-indexed behavioural model, plus literal burst checks.
module tb_chip_burst_engine;

    localparam int BL   = 8;
    localparam int CL   = 4;
    localparam int CWL  = 2;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd = '0;
    logic [1:0] bg = '0;
    logic [1:0] ba = '0;
    logic [4:0] row = '0;
    logic [9:0] column = '0;
    logic [3:0] dqin = '0;
    logic [3:0] dqout;
    logic       dq_valid;
    logic       err;

    chip_burst_engine #(
        .BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(5), .COLWIDTH(10),
        .DEVICE_WIDTH(4), .BL(BL), .CL(CL), .CWL(CWL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .bg(bg), .ba(ba), .row(row), .column(column), .dqin(dqin),
        .dqout(dqout), .dq_valid(dq_valid), .err(err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    // Model: expectations per cycle (cycle e = interval after edge e).
    bit         exp_valid [MAXC];
    logic [3:0] exp_data  [MAXC];
    bit         exp_busy  [MAXC];
    bit         exp_err   [MAXC];
    bit         m_open    [16];
    int         m_row     [16];
    logic [3:0] mm [int];

    typedef struct {
        int         e;
        logic [3:0] d;
    } beat_t;
    beat_t cap [$];

    task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, e, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (edge_n > 0 && edge_n < MAXC) begin
            chk("dq_valid", edge_n, 32'(dq_valid), 32'(exp_valid[edge_n]));
            chk("dqout", edge_n, 32'(dqout), exp_valid[edge_n] ? 32'(exp_data[edge_n]) : 32'd0);
            chk("cmd_ready", edge_n, 32'(cmd_ready), 32'(!exp_busy[edge_n]));
            chk("err", edge_n, 32'(err), 32'(exp_err[edge_n]));
        end
    end

    always @(negedge clk) begin
        if (dq_valid === 1'b1) cap.push_back('{edge_n, dqout});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int maddr(int g, int b, int r, int c);
        return (((g * 4 + b) * 32 + r) * 1024) + c;
    endfunction

    function automatic int bcol(int c, int k);
        return (c & ~(BL - 1)) | ((c + k) & (BL - 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset(input int r);
        for (int i = r; i < MAXC; i++) begin
            exp_valid[i] = 1'b0;
            exp_data[i]  = '0;
            exp_busy[i]  = 1'b0;
            exp_err[i]   = 1'b0;
        end
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
    endtask

    task automatic err_from(input int t);
        for (int i = t; i < MAXC; i++) exp_err[i] = 1'b1;
    endtask

    task automatic busy_span(input int a, input int b);
        for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
    endtask

    task automatic issue(input int c, input int g, input int b, input int r, input int col, output int t);
        int bk;
        bk = g * 4 + b;
        while (exp_busy[edge_n]) tick;
        cmd_valid = 1'b1;
        cmd       = 3'(c);
        bg        = 2'(g);
        ba        = 2'(b);
        row       = 5'(r);
        column    = 10'(col);
        t = edge_n + 1;
        case (c)
            0: ;
            1: begin
                if (m_open[bk]) err_from(t);
                else begin m_open[bk] = 1'b1; m_row[bk] = r; end
            end
            2: begin
                if (!m_open[bk]) err_from(t);
                else begin
                    for (int k = 0; k < BL; k++) begin
                        exp_valid[t + CL + k] = 1'b1;
                        exp_data[t + CL + k]  = mm[maddr(g, b, m_row[bk], bcol(col, k))];
                    end
                    busy_span(t, t + BL - 2);
                end
            end
            3: begin
                if (!m_open[bk]) err_from(t);
                else busy_span(t, t + CWL + BL - 2);
            end
            4: m_open[bk] = 1'b0;
            5: for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
            default: err_from(t);
        endcase
        tick;
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset(edge_n + 1);
        repeat (n) tick;
        rst_n = 1'b1;
    endtask

    // Write burst; abort_k < BL pulls reset on the edge that would sample beat abort_k.
    task automatic wr_burst(input int g, input int b, input int col, input logic [3:0] d [BL], input int abort_k);
        int  t;
        int  rl;
        bit  legal;
        legal = m_open[g * 4 + b];
        rl    = m_row[g * 4 + b];
        issue(3, g, b, 0, col, t);
        if (legal) begin
            for (int k = 0; k < BL; k++) begin
                while (edge_n < t + CWL + k - 1) tick;
                if (k == abort_k) begin
                    rst_n = 1'b0;
                    model_reset(edge_n + 1);
                    tick;
                    tick;
                    rst_n = 1'b1;
                    return;
                end
                dqin = d[k];
                mm[maddr(g, b, rl, bcol(col, k))] = d[k];
            end
            tick;
        end
    endtask

    task automatic rd_check(input string nm, input int g, input int b, input int col, input logic [3:0] expd [BL]);
        int t;
        cap.delete();
        issue(2, g, b, 0, col, t);
        while (edge_n < t + CL + BL + 1) tick;
        chk({nm, "_count"}, edge_n, 32'(cap.size()), 32'(BL));
        if (cap.size() == BL) begin
            for (int k = 0; k < BL; k++) begin
                chk({nm, "_time"}, cap[k].e, 32'(cap[k].e - t), 32'(CL + k));
                chk({nm, "_data"}, cap[k].e, 32'(cap[k].d), 32'(expd[k]));
            end
        end
    endtask

    task automatic rd_dropped(input string nm, input int g, input int b);
        int t;
        cap.delete();
        issue(2, g, b, 0, 0, t);
        repeat (CL + BL + 2) tick;
        chk({nm, "_no_dq"}, edge_n, 32'(cap.size()), 32'd0);
    endtask

    logic [3:0] rnd   [BL];
    logic [3:0] wseq  [BL];
    logic [3:0] wrap  [BL];
    logic [3:0] pa    [BL];
    logic [3:0] pb    [BL];
    logic [3:0] pn    [BL];
    logic [3:0] mixed [BL];
    int t1, t2, tx;

    initial begin
        wseq  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        wrap  = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h1, 4'h2, 4'h3};
        pa    = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        pb    = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};
        pn    = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h0};
        mixed = '{4'hF, 4'hE, 4'hD, 4'h7, 4'h8, 4'h1, 4'h2, 4'h3};
        for (int k = 0; k < BL; k++) rnd[k] = 4'($urandom);

        // Reset state
        do_reset(2);
        chk("rst_ready", edge_n, 32'(cmd_ready), 32'd1);
        chk("rst_dq_valid", edge_n, 32'(dq_valid), 32'd0);
        chk("rst_dqout", edge_n, 32'(dqout), 32'd0);
        chk("rst_err", edge_n, 32'(err), 32'd0);

        // Basic write then read, CL latency
        issue(1, 1, 1, 1, 0, tx);
        wr_burst(1, 1, 0, rnd, BL);
        rd_check("basic", 1, 1, 0, rnd);

        // Wrap order within the aligned block
        wr_burst(1, 1, 5, wseq, BL);
        rd_check("wrap", 1, 1, 0, wrap);

        // RD to a closed bank
        rd_dropped("closed", 0, 0);
        chk("closed_err", edge_n, 32'(err), 32'd1);

        // ACT on an open bank leaves row 1 open
        issue(1, 1, 1, 2, 0, tx);
        rd_check("react", 1, 1, 0, wrap);

        // PRE then RD, PREA then RD
        issue(4, 1, 1, 0, 0, tx);
        rd_dropped("pre", 1, 1);
        issue(1, 2, 3, 7, 0, tx);
        issue(5, 0, 0, 0, 0, tx);
        rd_dropped("prea", 2, 3);

        // Illegal opcode from a clean reset
        do_reset(2);
        chk("clean_err", edge_n, 32'(err), 32'd0);
        issue(7, 0, 0, 0, 0, tx);
        chk("illegal_err", edge_n, 32'(err), 32'd1);
        do_reset(2);

        // Bank isolation and back-to-back reads
        issue(1, 1, 1, 1, 0, tx);
        issue(1, 2, 3, 7, 0, tx);
        wr_burst(1, 1, 16, pa, BL);
        wr_burst(2, 3, 16, pb, BL);
        cap.delete();
        issue(2, 1, 1, 0, 16, t1);
        issue(2, 2, 3, 0, 16, t2);
        while (edge_n < t2 + CL + BL + 1) tick;
        chk("b2b_gap", edge_n, 32'(t2 - t1), 32'(BL));
        chk("b2b_count", edge_n, 32'(cap.size()), 32'(2 * BL));
        if (cap.size() == 2 * BL) begin
            for (int k = 0; k < 2 * BL; k++) begin
                chk("b2b_time", cap[k].e, 32'(cap[k].e - t1), 32'(CL + k));
                chk("b2b_data", cap[k].e, 32'(cap[k].d), 32'(k < BL ? pa[k] : pb[k - BL]));
            end
        end

        // Reset during beat 3 of a write
        wr_burst(1, 1, 0, pn, 3);
        chk("abort_ready", edge_n, 32'(cmd_ready), 32'd1);
        chk("abort_dq_valid", edge_n, 32'(dq_valid), 32'd0);
        issue(1, 1, 1, 1, 0, tx);
        rd_check("abort", 1, 1, 0, mixed);

        repeat (3) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
